// File: rtl/stage_pkg.sv
// Shared types and phase numbering for the instruction stage sequencer.
// The phase constants name the default nine-phase instruction cycle.
package stage_pkg;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   localparam int PH_IF    = 0;
   localparam int PH_ID    = 1;
   localparam int PH_RF    = 2;
   localparam int PH_EX    = 3;
   localparam int PH_AG    = 4;
   localparam int PH_MEM   = 5;
   localparam int PH_ALIGN = 6;
   localparam int PH_WB    = 7;
   localparam int PH_WB_IF = 8;

   localparam int DEFAULT_NUM_PHASES = PH_WB_IF + 1;

endpackage

// File: rtl/stage_sequencer.sv
// Walks each instruction through NUM_PHASES one-hot phases with stall, flush
// and halt-at-boundary control, and counts retired instructions.
module stage_sequencer
   import stage_pkg::*;
#(
   parameter int                    NUM_PHASES  = DEFAULT_NUM_PHASES,
   parameter logic [NUM_PHASES-1:0] WAIT_MASK   = NUM_PHASES'(9'h021),
   parameter int                    INIT_CYCLES = 2,
   parameter int                    COUNT_W     = 32
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          run,
   input  logic                          halt_req,
   input  logic                          stall,
   input  logic                          flush,
   output logic [NUM_PHASES-1:0]         phase_act,
   output logic [NUM_PHASES-1:0]         phase_fire,
   output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
   output logic                          stage_reset_n,
   output logic                          busy,
   output logic                          retire_pulse,
   output logic [COUNT_W-1:0]            retire_count
);

   localparam int IDX_W  = $clog2(NUM_PHASES);
   localparam int INIT_W = $clog2(INIT_CYCLES) + 1;

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_PHASES - 1);
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

   state_e                 state_q, state_d;
   logic [INIT_W-1:0]      init_cnt_q, init_cnt_d;
   logic [IDX_W-1:0]       phase_idx_q, phase_idx_d;
   logic                   halt_pending_q, halt_pending_d;
   logic [COUNT_W-1:0]     retire_count_q, retire_count_d;
   logic [NUM_PHASES-1:0]  phase_act_q, phase_act_d;
   logic                   busy_q, busy_d;
   logic                   stage_reset_n_q, stage_reset_n_d;

   logic hold;
   logic fire_en;
   logic last_phase;

   // Completion depends on this cycle's stall/flush, so fire and retire stay combinational.
   always_comb begin
      hold         = stall && WAIT_MASK[phase_idx_q];
      fire_en      = (state_q == ST_RUN) && !flush && !hold;
      last_phase   = (phase_idx_q == LAST_IDX);
      phase_fire   = fire_en ? (NUM_PHASES'(1) << phase_idx_q) : '0;
      retire_pulse = fire_en && last_phase;
   end

   // NOTE: every _d gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d        = state_q;
      init_cnt_d     = '0;
      phase_idx_d    = phase_idx_q;
      retire_count_d = retire_count_q;
      halt_pending_d = halt_pending_q | halt_req;

      unique case (state_q)
         ST_INIT: begin
            if (init_cnt_q == INIT_LAST) begin
               state_d = ST_IDLE;
            end else begin
               init_cnt_d = init_cnt_q + INIT_W'(1);
            end
         end
         ST_IDLE: begin
            if (run && !halt_pending_q) begin
               state_d     = ST_RUN;
               phase_idx_d = '0;
            end
         end
         ST_RUN: begin
            if (flush) begin
               phase_idx_d = '0;
            end else if (!hold) begin
               if (last_phase) begin
                  phase_idx_d    = '0;
                  retire_count_d = retire_count_q + COUNT_W'(1);
                  if (halt_pending_q || !run) begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  phase_idx_d = phase_idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = ST_INIT;
      endcase

      // Arriving in IDLE consumes the halt request, overriding a same-cycle set.
      if (state_d == ST_IDLE && state_q != ST_IDLE) begin
         halt_pending_d = 1'b0;
      end

      busy_d          = (state_d == ST_RUN);
      stage_reset_n_d = (state_d != ST_INIT);
      phase_act_d     = busy_d ? (NUM_PHASES'(1) << phase_idx_d) : '0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_INIT;
         init_cnt_q      <= '0;
         phase_idx_q     <= '0;
         halt_pending_q  <= 1'b0;
         retire_count_q  <= '0;
         phase_act_q     <= '0;
         busy_q          <= 1'b0;
         stage_reset_n_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         init_cnt_q      <= init_cnt_d;
         phase_idx_q     <= phase_idx_d;
         halt_pending_q  <= halt_pending_d;
         retire_count_q  <= retire_count_d;
         phase_act_q     <= phase_act_d;
         busy_q          <= busy_d;
         stage_reset_n_q <= stage_reset_n_d;
      end
   end

   assign phase_act     = phase_act_q;
   assign phase_idx     = phase_idx_q;
   assign stage_reset_n = stage_reset_n_q;
   assign busy          = busy_q;
   assign retire_count  = retire_count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed scenarios plus random
// stall/flush/run/halt traffic against a cycle-level behavioural model.
module tb_stage_sequencer;

   localparam int               NP    = 9;
   localparam logic [NP-1:0]    MASK  = 9'h021;
   localparam int               INITC = 2;
   localparam int               CW    = 4;

   localparam int M_INIT = 0;
   localparam int M_IDLE = 1;
   localparam int M_RUN  = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          run = 1'b0;
   logic          halt_req = 1'b0;
   logic          stall = 1'b0;
   logic          flush = 1'b0;
   logic [NP-1:0] phase_act;
   logic [NP-1:0] phase_fire;
   logic [3:0]    phase_idx;
   logic          stage_reset_n;
   logic          busy;
   logic          retire_pulse;
   logic [CW-1:0] retire_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: mode, cycles of INIT left, current phase, pending halt, retired count.
   int m_mode;
   int m_init_left;
   int m_phase;
   bit m_halt;
   int m_count;

   logic [NP-1:0] obs_fire;
   logic          obs_retire;

   stage_sequencer #(
      .NUM_PHASES  (NP),
      .WAIT_MASK   (MASK),
      .INIT_CYCLES (INITC),
      .COUNT_W     (CW)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .run           (run),
      .halt_req      (halt_req),
      .stall         (stall),
      .flush         (flush),
      .phase_act     (phase_act),
      .phase_fire    (phase_fire),
      .phase_idx     (phase_idx),
      .stage_reset_n (stage_reset_n),
      .busy          (busy),
      .retire_pulse  (retire_pulse),
      .retire_count  (retire_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode      = M_INIT;
      m_init_left = INITC;
      m_phase     = 0;
      m_halt      = 1'b0;
      m_count     = 0;
   endtask

   task automatic check_outputs();
      bit            in_run;
      bit            completes;
      logic [31:0]   e_act;
      logic [31:0]   e_fire;
      in_run    = (m_mode == M_RUN);
      completes = in_run && !flush && !(stall && MASK[m_phase]);
      e_act     = in_run ? (32'd1 << m_phase) : 32'd0;
      e_fire    = completes ? (32'd1 << m_phase) : 32'd0;
      check("phase_act",     32'(phase_act),     e_act);
      check("phase_fire",    32'(phase_fire),    e_fire);
      check("phase_idx",     32'(phase_idx),     32'(m_phase));
      check("stage_reset_n", 32'(stage_reset_n), 32'(m_mode != M_INIT));
      check("busy",          32'(busy),          32'(in_run));
      check("retire_pulse",  32'(retire_pulse),  32'(completes && m_phase == NP - 1));
      check("retire_count",  32'(retire_count),  32'(m_count));
   endtask

   task automatic model_advance();
      bit to_idle;
      to_idle = 1'b0;
      case (m_mode)
         M_INIT: begin
            m_init_left--;
            if (m_init_left == 0) begin
               m_mode  = M_IDLE;
               to_idle = 1'b1;
            end
         end
         M_IDLE: begin
            if (run && !m_halt) begin
               m_mode  = M_RUN;
               m_phase = 0;
            end
         end
         default: begin
            if (flush) begin
               m_phase = 0;
            end else if (!(stall && MASK[m_phase])) begin
               if (m_phase == NP - 1) begin
                  m_count = (m_count + 1) % (1 << CW);
                  m_phase = 0;
                  if (m_halt || !run) begin
                     m_mode  = M_IDLE;
                     to_idle = 1'b1;
                  end
               end else begin
                  m_phase++;
               end
            end
         end
      endcase
      m_halt = to_idle ? 1'b0 : (m_halt | halt_req);
   endtask

   // One clock: drive inputs, compare at the falling edge, then advance the model.
   task automatic step(input bit r, input bit h, input bit s, input bit f);
      run      = r;
      halt_req = h;
      stall    = s;
      flush    = f;
      @(negedge clk);
      check_outputs();
      obs_fire   = phase_fire;
      obs_retire = retire_pulse;
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      run      = 1'b1;
      stall    = 1'b1;
      flush    = 1'b1;
      halt_req = 1'b0;
      reset_n  = 1'b0;
      #1;
      check("rst_phase_act",     32'(phase_act),     32'd0);
      check("rst_phase_fire",    32'(phase_fire),    32'd0);
      check("rst_phase_idx",     32'(phase_idx),     32'd0);
      check("rst_stage_reset_n", 32'(stage_reset_n), 32'd0);
      check("rst_busy",          32'(busy),          32'd0);
      check("rst_retire_pulse",  32'(retire_pulse),  32'd0);
      check("rst_retire_count",  32'(retire_count),  32'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic goto_phase(input int ph, input string tag);
      int k;
      for (k = 0; k < 40; k++) begin
         if (m_mode == M_RUN && m_phase == ph) break;
         step(1, 0, 0, 0);
      end
      if (k == 40) check(tag, 32'd0, 32'd1);
   endtask

   task automatic measure_instr(input int sph, input int sn, output int len,
                                output int act_n, output int fire_n);
      int stalled;
      bit done;
      bit s;
      len     = 0;
      act_n   = 0;
      fire_n  = 0;
      stalled = 0;
      done    = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         s = (m_mode == M_RUN && m_phase == sph && stalled < sn);
         if (s) stalled++;
         if (busy) len++;
         if (phase_act[sph]) act_n++;
         step(1, 0, s, 0);
         if (obs_fire[sph]) fire_n++;
         if (obs_retire) done = 1'b1;
      end
      if (!done) check("instr_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int len, act_n, fire_n, cnt, saved, retires;
      bit r, s, f, h;

      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Init window length.
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (stage_reset_n) break;
         cnt++;
         step(1, 0, 0, 0);
      end
      check("init_len", 32'(cnt), 32'(INITC));

      measure_instr(0, 0, len, act_n, fire_n);
      check("plain_len", 32'(len), 32'd9);
      check("plain_count", 32'(retire_count), 32'd1);

      measure_instr(5, 3, len, act_n, fire_n);
      check("stall5_len", 32'(len), 32'd12);
      check("stall5_act", 32'(act_n), 32'd4);
      check("stall5_fire", 32'(fire_n), 32'd1);

      measure_instr(2, 100, len, act_n, fire_n);
      check("stall2_len", 32'(len), 32'd9);

      goto_phase(5, "reach_flush_phase");
      saved = int'(retire_count);
      step(1, 0, 1, 1);
      check("flush_fire", 32'(obs_fire), 32'd0);
      check("flush_idx", 32'(phase_idx), 32'd0);
      check("flush_count", 32'(retire_count), 32'(saved));

      goto_phase(3, "reach_halt_phase");
      step(1, 1, 0, 0);
      cnt = 0;
      while (!obs_retire && cnt < 20) begin
         step(1, 0, 0, 0);
         cnt++;
      end
      check("halt_retired", 32'(obs_retire), 32'd1);
      check("halt_busy", 32'(busy), 32'd0);
      step(0, 0, 0, 0);
      check("idle_busy", 32'(busy), 32'd0);
      step(1, 0, 0, 0);
      check("restart_busy", 32'(busy), 32'd1);
      check("restart_idx", 32'(phase_idx), 32'd0);
      check("restart_act", 32'(phase_act), 32'd1);

      // Counter wrap with a 4-bit counter, then reset mid-instruction.
      do_reset();
      retires = 0;
      for (int k = 0; k < 200 && retires < 17; k++) begin
         step(1, 0, 0, 0);
         if (obs_retire) retires++;
      end
      check("wrap_retires", 32'(retires), 32'd17);
      check("wrap_count", 32'(retire_count), 32'd1);
      goto_phase(4, "reach_reset_phase");
      do_reset();

      for (int k = 0; k < 800; k++) begin
         if (k == 400) do_reset();
         r = ($urandom_range(0, 9) != 0);
         s = ($urandom_range(0, 2) == 0);
         f = ($urandom_range(0, 19) == 0);
         h = (m_mode == M_RUN && m_phase != NP - 1 && $urandom_range(0, 29) == 0);
         step(r, h, s, f);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 The module SHALL have parameter NUM_PHASES, default 9, meaning the number of phases per instruction (index 0 = IF ... 8 = WB_IF), minimum 2.
REQ-002 The module SHALL have parameter WAIT_MASK, NUM_PHASES bits, default 9'h021, meaning the phases that may be held by stall (IF, MEM).
REQ-003 The module SHALL have parameter INIT_CYCLES, default 2, meaning the cycles stage_reset_n is held low after reset, minimum 1.
REQ-004 The module SHALL have parameter COUNT_W, default 32, meaning the width of the retired-instruction counter.
REQ-005 The ports SHALL be (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  permission to start an instruction from IDLE.
- halt_req  in  1  request to stop at the next instruction boundary.
- stall  in  1  hold the current phase when that phase's WAIT_MASK bit is 1.
- flush  in  1  abort the current instruction and restart at phase 0.
- phase_act  out  NUM_PHASES  one-hot level: the sequencer is in phase i.
- phase_fire  out  NUM_PHASES  one-hot, single-cycle pulse: phase i completes this cycle (write enable).
- phase_idx  out  $clog2(NUM_PHASES)  current phase number.
- stage_reset_n  out  1  active-low synchronous reset to the pipeline registers.
- busy  out  1  the sequencer is in RUN.
- retire_pulse  out  1  an instruction completed this cycle.
- retire_count  out  COUNT_W  count of retired instructions.

Function
REQ-006 The state machine SHALL have states INIT, IDLE and RUN.
REQ-007 INIT SHALL drive stage_reset_n=0 for exactly INIT_CYCLES cycles and then go to IDLE.
REQ-008 IDLE SHALL go to RUN with phase_idx=0 on the cycle after run=1 is sampled while halt_pending=0.
REQ-009 In RUN, phase_act[phase_idx] SHALL be 1; in INIT and IDLE, phase_act SHALL be all zero.
REQ-010 A phase SHALL hold when stall=1 and WAIT_MASK[phase_idx]=1, and phase_fire SHALL be 0 while it holds.
REQ-011 A phase SHALL complete when it is not held and flush=0; on completion phase_fire[phase_idx]=1 for that cycle and phase_idx advances by 1 on the next edge.
REQ-012 Completion of phase NUM_PHASES-1 SHALL assert retire_pulse and increment retire_count, wrapping modulo 2^COUNT_W.
REQ-013 Completion of phase NUM_PHASES-1 SHALL set phase_idx to 0; the state goes to IDLE if halt_pending=1 or run=0, and stays in RUN otherwise.
REQ-014 stall SHALL be ignored in phases whose WAIT_MASK bit is 0.
REQ-015 flush in RUN SHALL force phase_fire=0 and retire_pulse=0 that cycle, and set phase_idx=0 next cycle; flush takes priority over stall and completion.
REQ-016 flush SHALL be ignored in INIT and IDLE.
REQ-017 halt_req=1 in any cycle SHALL set internal halt_pending; halt_pending clears when the state enters IDLE.
REQ-018 halt_req SHALL NOT abort the instruction in flight.
REQ-019 phase_fire and retire_pulse SHALL be combinational from registered state and the current stall/flush inputs; every other output SHALL be registered.
REQ-020 At most one bit of phase_fire SHALL be set in any cycle.

Reset
REQ-021 While reset_n=0, the module SHALL hold: state=INIT, INIT counter=0, phase_idx=0, halt_pending=0, retire_count=0, stage_reset_n=0, busy=0, phase_act=0, phase_fire=0, retire_pulse=0.
REQ-022 Reset asserted mid-instruction SHALL abandon that instruction without a retire pulse.
REQ-023 After reset releases, INIT SHALL run again for INIT_CYCLES cycles.

Structure
REQ-024 The state enum (INIT/IDLE/RUN) and default phase-index constants (PH_IF=0 ... PH_WB_IF=8) SHALL live in shared package stage_pkg.
REQ-025 The block SHALL be a single module with no sub-modules; the retire counter is inline.

Verification
REQ-026 Reset, run=1, no stall: stage_reset_n low for 2 cycles; phase_fire walks bits 0..8 over 9 consecutive cycles; retire_pulse=1 with phase_fire[8]; retire_count=1.
REQ-027 stall=1 for 3 cycles in phase 5: phase_act[5] high for 4 cycles with one phase_fire[5]; instruction takes 12 cycles.
REQ-028 stall=1 held through phase 2: no effect; the instruction still takes 9 cycles.
REQ-029 flush and stall together in phase 5: phase_fire=0 that cycle, phase_idx=0 next cycle, retire_count unchanged.
REQ-030 halt_req pulsed in phase 3 with run=1: the instruction completes, state goes to IDLE, busy=0; a later run=1 restarts at phase 0.
REQ-031 COUNT_W=4 with 17 instructions: retire_count wraps to 1; reset_n dropped in phase 4 clears all outputs immediately.
